// File: rtl/cp0_unit_if.sv
// M-stage <-> CP0 bundle: mtc0/mfc0 access, exception/interrupt inputs, and the Req/EPC results.
// The pipeline side uses the master modport; the coprocessor uses the slave modport.
interface cp0_unit_if;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        en;
  logic [31:0] PC_M;
  logic        BD_M;
  logic [4:0]  ExcCode_M;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        Req;
  logic [31:0] EPC_out;
  logic [31:0] CP0Out;

  modport master (
    output A1, A2, DIn, en, PC_M, BD_M, ExcCode_M, HWInt, EXLClr,
    input  Req, EPC_out, CP0Out
  );

  modport slave (
    input  A1, A2, DIn, en, PC_M, BD_M, ExcCode_M, HWInt, EXLClr,
    output Req, EPC_out, CP0Out
  );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR/Cause/EPC/PRId, exception and interrupt entry, mtc0/mfc0, eret EXL clear.
// Req, EPC_out and CP0Out are combinational; state updates take one edge; no backpressure.
module cp0_unit #(
  parameter logic [31:0] PRID     = 32'h2023_0007,
  parameter logic [5:0]  IM_RESET = 6'b000000
) (
  input logic        clk,
  input logic        reset,
  cp0_unit_if.slave  bus
);

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic        req;
  logic        wr_sr;
  logic        wr_epc;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  always_comb begin
    int_req = (|(bus.HWInt & im)) & ie & ~exl;
    exc_req = (bus.ExcCode_M != 5'd0) & ~exl;
    req     = (int_req | exc_req) & ~reset;
    wr_sr   = bus.en & (bus.A2 == REG_SR);
    wr_epc  = bus.en & (bus.A2 == REG_EPC);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im       <= IM_RESET;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= 6'd0;
      exc_code <= 5'd0;
      epc      <= 32'd0;
    end else begin
      ip <= bus.HWInt;
      if (req) begin
        exl      <= 1'b1;
        bd       <= bus.BD_M;
        // An interrupt outranks a simultaneous exception.
        exc_code <= int_req ? 5'd0 : bus.ExcCode_M;
        epc      <= bus.BD_M ? (bus.PC_M - 32'd4) : bus.PC_M;
      end else begin
        if (wr_sr) begin
          im  <= bus.DIn[15:10];
          exl <= bus.DIn[1];
          ie  <= bus.DIn[0];
        end
        if (wr_epc) begin
          epc <= bus.DIn;
        end
        // eret wins over an mtc0 SR write landing on the same edge.
        if (bus.EXLClr) begin
          exl <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    sr_word    = {16'd0, im, 8'd0, exl, ie};
    cause_word = {bd, 15'd0, ip, 3'd0, exc_code, 2'd0};
  end

  always_comb begin
    bus.Req     = req;
    // Forward an in-flight mtc0 EPC so an immediately following eret sees it.
    bus.EPC_out = (wr_epc && !req) ? bus.DIn : epc;
    case (bus.A1)
      REG_SR:    bus.CP0Out = sr_word;
      REG_CAUSE: bus.CP0Out = cause_word;
      REG_EPC:   bus.CP0Out = epc;
      REG_PRID:  bus.CP0Out = PRID;
      default:   bus.CP0Out = 32'd0;
    endcase
  end

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor-0 for the P7 pipelined MIPS core; sits beside the M stage.
- Holds SR, Cause, EPC and PRId. Decides exception/interrupt entry and drives the Req and EPC values that the next-PC logic consumes.
- Executes mtc0/mfc0 and the eret EXL clear.

Parameters:
- PRID, 32'h2023_0007, constant value returned for register 15.
- IM_RESET, 6'b000000, SR.IM value after reset.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- A1  input  5  mfc0 read register number
- A2  input  5  mtc0 write register number
- DIn  input  32  mtc0 write data
- en  input  1  mtc0 write enable (M stage)
- PC_M  input  32  PC of the M-stage instruction
- BD_M  input  1  M-stage instruction is in a branch delay slot
- ExcCode_M  input  5  M-stage exception code; 0 = none
- HWInt  input  6  external interrupt lines, level-sensitive
- EXLClr  input  1  eret in M stage
- Req  output  1  take exception/interrupt this cycle (combinational)
- EPC_out  output  32  EPC value for eret
- CP0Out  output  32  mfc0 read data (combinational)

Behaviour:
- Clock and reset:
  - One clock domain: clk.
  - reset is synchronous and active-high. At the rising edge with reset=1, every register is loaded: SR={16'b0, IM_RESET, 8'b0, EXL=0, IE=0}, Cause=0, EPC=0.
  - While reset=1, Req is forced to 0.
- SR layout: IM=SR[15:10], EXL=SR[1], IE=SR[0]. All other bits read 0.
- Cause layout: BD=Cause[31], IP=Cause[15:10], ExcCode=Cause[6:2]. All other bits read 0.
- Request logic, combinational, same cycle:
  - IntReq = |(HWInt & IM) & IE & ~EXL.
  - ExcReq = (ExcCode_M != 0) & ~EXL.
  - Req = (IntReq | ExcReq) & ~reset.
- Cause.IP is loaded from HWInt every non-reset cycle, regardless of Req.
- On a clock edge with Req=1:
  - EXL <= 1.
  - Cause.BD <= BD_M.
  - Cause.ExcCode <= IntReq ? 5'd0 : ExcCode_M. An interrupt outranks a simultaneous exception.
  - EPC <= BD_M ? PC_M - 32'd4 : PC_M, with 32-bit wrap-around: PC_M=0 with BD_M=1 gives 32'hFFFF_FFFC.
- mtc0 (en=1, Req=0):
  - A2=12 writes SR, only bits [15:10] and [1:0].
  - A2=14 writes EPC in full.
  - A2=13, A2=15 and any other number are ignored.
  - Writes take effect at the edge and are visible to CP0Out/Req on the next cycle.
- EXLClr=1 with Req=0: EXL <= 0 at the edge.
- Priority at one edge: reset > Req > (mtc0, EXLClr).
  - Req suppresses both mtc0 and the EXL clear.
  - If mtc0 to SR and EXLClr arrive together, the mtc0 data is written first, then EXL is forced to 0.
- EPC_out:
  - Equals DIn when en=1 and A2=14, and Req=0. This bypass covers mtc0 EPC immediately followed by eret.
  - Otherwise equals the EPC register.
- CP0Out by A1: 12 returns SR, 13 returns Cause, 14 returns EPC register, 15 returns PRID, anything else returns 0. No write-to-read bypass.
- Latency:
  - Req is zero-latency (same cycle as the cause).
  - State updates are one edge.
  - Repeated requests are blocked while EXL=1 until eret.

Test Plan:
- Reset with all inputs 0, then read A1=12, 13, 14, 15 -> Req=0; CP0Out = 32'h0, 32'h0, 32'h0, 32'h2023_0007.
- Exception: ExcCode_M=5'd10, PC_M=32'h0000_3010, BD_M=0 -> Req=1 that cycle. After the edge: EPC=32'h3010, Cause=32'h0000_0028, SR.EXL=1. Same stimulus on the next cycle -> Req=0.
- Delay-slot exception: ExcCode_M=4, PC_M=32'h3008, BD_M=1 -> EPC=32'h3004, Cause[31]=1, ExcCode=4.
- Interrupt vs exception: mtc0 SR=32'h0000_0401 (IM[10]=1, IE=1), then HWInt=6'b000001 together with ExcCode_M=12 -> Req=1; Cause.ExcCode=0, Cause.IP=6'b000001. With HWInt=6'b000010 instead -> no interrupt, exception taken with ExcCode=12.
- eret/bypass: with EXL=1, assert en=1, A2=14, DIn=32'h0000_4000, EXLClr=1 in the same cycle -> EPC_out=32'h4000 combinationally. Next cycle: EPC=32'h4000, EXL=0, and a pending ExcCode_M=4 raises Req=1.
- Priority and reset: Req=1 together with en=1, A2=12, DIn=0 -> SR.EXL becomes 1 and IE/IM are unchanged. Then assert reset together with ExcCode_M=4 -> Req=0 and all registers cleared at the edge.
